// File: rtl/spi_pkg.sv
// Shared types and helpers for the parametrised SPI master.
// Holds the FSM state encoding, command-bit values and SPI mode decoding.
package spi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StXfer,
    StHold,
    StDone
  } spi_state_e;

  localparam logic CMD_WRITE = 1'b1;
  localparam logic CMD_READ  = 1'b0;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  function automatic spi_mode_t mode_decode(input logic [1:0] mode);
    spi_mode_t m;
    m.cpol = mode[1];
    m.cpha = mode[0];
    return m;
  endfunction

endpackage

// File: rtl/spi_master_param_if.sv
// Host-side request/response bus of the SPI master.
// The master modport belongs to the requester, the slave modport to the SPI block.
interface spi_master_param_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NUM_CS = 2
);
  localparam int unsigned CSW = $clog2(NUM_CS) + 1;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [CSW-1:0]    req_cs;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] rsp_rdata;
  logic              done;
  logic              error;

  modport master (
    output req_valid, req_write, req_cs, req_addr, req_wdata,
    input  req_ready, rsp_rdata, done, error
  );

  modport slave (
    input  req_valid, req_write, req_cs, req_addr, req_wdata,
    output req_ready, rsp_rdata, done, error
  );

endinterface

// File: rtl/spi_clk_gen.sv
// SCLK generator: half-period counter, registered sclk and edge strobes.
// Counts while en is high; sclk only toggles at terminal count while run is high.
module spi_clk_gen #(
  parameter int unsigned CLK_DIV = 2,
  parameter logic        CPOL    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic run,
  output logic half_tc,
  output logic lead_edge,
  output logic trail_edge,
  output logic sclk
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic          sclk_q;

  assign half_tc    = en && (cnt_q == CNT_MAX);
  // Strobes describe the edge sclk takes at the coming clk edge.
  assign lead_edge  = half_tc && run && (sclk_q == CPOL);
  assign trail_edge = half_tc && run && (sclk_q != CPOL);
  assign sclk       = sclk_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      sclk_q <= CPOL;
    end else begin
      if (!en || half_tc) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (run && half_tc) begin
        sclk_q <= ~sclk_q;
      end
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master: one framed read or write (cmd, addr, data; MSB first)
// per accepted request, with done/error pulses and a held read-data register.
module spi_master_param
  import spi_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NUM_CS   = 2,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned SPI_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  spi_master_param_if.slave bus,
  output logic              sclk,
  output logic [NUM_CS-1:0] cs_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int unsigned FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int unsigned CSW     = $clog2(NUM_CS) + 1;
  localparam int unsigned HPW     = $clog2(2 * FRAME_W + 1);
  localparam spi_mode_t   MODE    = mode_decode(2'(SPI_MODE));
  localparam logic        CPOL    = MODE.cpol;
  localparam logic        CPHA    = MODE.cpha;
  localparam logic [HPW-1:0] HP_LAST = HPW'(2 * FRAME_W - 1);

  spi_state_e          state_q;
  logic [FRAME_W-1:0]  frame_q;
  logic [HPW-1:0]      hp_q;
  logic [DATA_W-1:0]   rx_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                rd_q;
  logic                done_q;
  logic                error_q;
  logic                mosi_q;
  logic [NUM_CS-1:0]   cs_n_q;

  logic                en;
  logic                run;
  logic                half_tc;
  logic                lead_edge;
  logic                trail_edge;
  logic                shift_ev;
  logic                samp_ev;
  logic                accept;
  logic                cs_bad;
  logic [DATA_W-1:0]   wdata_sel;
  logic [FRAME_W-1:0]  frame_init;

  assign accept     = bus.req_valid && (state_q == StIdle);
  assign cs_bad     = bus.req_cs >= CSW'(NUM_CS);
  assign wdata_sel  = bus.req_write ? bus.req_wdata : {DATA_W{1'b0}};
  assign frame_init = {(bus.req_write ? CMD_WRITE : CMD_READ), bus.req_addr, wdata_sel};

  assign en  = (state_q == StSetup) || (state_q == StXfer) || (state_q == StHold);
  // The end of SETUP is the first leading edge; the last XFER half-period ends without one.
  assign run = (state_q == StSetup) || ((state_q == StXfer) && (hp_q != HP_LAST));

  assign shift_ev = CPHA ? lead_edge  : trail_edge;
  assign samp_ev  = CPHA ? trail_edge : lead_edge;

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV),
    .CPOL    (CPOL)
  ) u_clk_gen (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .run        (run),
    .half_tc    (half_tc),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge),
    .sclk       (sclk)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      frame_q <= '0;
      hp_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      rd_q    <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= '1;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;

      if (shift_ev) begin
        mosi_q  <= frame_q[FRAME_W-1];
        frame_q <= {frame_q[FRAME_W-2:0], 1'b0};
      end
      if (samp_ev) begin
        rx_q <= DATA_W'({rx_q, miso});
      end

      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (cs_bad) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              error_q <= 1'b1;
              rd_q    <= 1'b0;
            end else begin
              state_q <= StSetup;
              rd_q    <= !bus.req_write;
              cs_n_q  <= ~(NUM_CS'(1) << bus.req_cs);
              hp_q    <= '0;
              rx_q    <= '0;
              // CPHA=0 presents the command bit for the whole of SETUP.
              if (CPHA) begin
                frame_q <= frame_init;
                mosi_q  <= 1'b0;
              end else begin
                frame_q <= {frame_init[FRAME_W-2:0], 1'b0};
                mosi_q  <= frame_init[FRAME_W-1];
              end
            end
          end
        end
        StSetup: begin
          if (half_tc) begin
            state_q <= StXfer;
          end
        end
        StXfer: begin
          if (half_tc) begin
            if (hp_q == HP_LAST) begin
              state_q <= StHold;
            end else begin
              hp_q <= hp_q + 1'b1;
            end
          end
        end
        StHold: begin
          if (half_tc) begin
            state_q <= StDone;
            done_q  <= 1'b1;
            cs_n_q  <= '1;
            mosi_q  <= 1'b0;
          end
        end
        StDone: begin
          state_q <= StIdle;
          if (rd_q) begin
            rdata_q <= rx_q;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_rdata = rdata_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;
  assign cs_n          = cs_n_q;
  assign mosi          = mosi_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: a mode-0/CLK_DIV=2 instance and a mode-3/CLK_DIV=1 instance
// checked against a frame-level model with a behavioural SPI slave.
module tb_spi_master_param;

  logic       clk = 1'b0;
  logic       rst;
  bit         sel;
  logic       req_valid;
  logic       req_write;
  logic [1:0] req_cs;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       miso;

  logic       sclk0, sclk1, mosi0, mosi1;
  logic [1:0] cs_n0, cs_n1;

  logic       m_sclk, m_mosi, m_ready, m_done, m_error;
  logic [1:0] m_cs_n;
  logic [7:0] m_rdata;

  int n_checks = 0;
  int n_errors = 0;

  // Monitor / slave state
  logic [7:0] slave_data;
  logic       prev_sclk, prev_mosi;
  logic [1:0] prev_cs_n;
  int         sclk_cnt = 0;
  int         done_cnt = 0;
  int         sh_cnt = 0;
  int         idx;
  int         cap_val = 0;
  int         n_cap = 0;
  int         mosi_viol = 0;
  int         cs_viol = 0;
  int         last_wait;
  logic [7:0] exp_rdata [2];

  always #5 clk = ~clk;

  spi_master_param_if #(.ADDR_W(8), .DATA_W(8), .NUM_CS(2)) bus0 ();
  spi_master_param_if #(.ADDR_W(8), .DATA_W(8), .NUM_CS(2)) bus1 ();

  assign bus0.req_valid = req_valid & ~sel;
  assign bus1.req_valid = req_valid & sel;
  assign bus0.req_write = req_write;
  assign bus1.req_write = req_write;
  assign bus0.req_cs    = req_cs;
  assign bus1.req_cs    = req_cs;
  assign bus0.req_addr  = req_addr;
  assign bus1.req_addr  = req_addr;
  assign bus0.req_wdata = req_wdata;
  assign bus1.req_wdata = req_wdata;

  spi_master_param #(
    .ADDR_W(8), .DATA_W(8), .NUM_CS(2), .CLK_DIV(2), .SPI_MODE(0)
  ) u0 (
    .clk(clk), .rst(rst), .bus(bus0.slave),
    .sclk(sclk0), .cs_n(cs_n0), .mosi(mosi0), .miso(miso)
  );

  spi_master_param #(
    .ADDR_W(8), .DATA_W(8), .NUM_CS(2), .CLK_DIV(1), .SPI_MODE(3)
  ) u1 (
    .clk(clk), .rst(rst), .bus(bus1.slave),
    .sclk(sclk1), .cs_n(cs_n1), .mosi(mosi1), .miso(miso)
  );

  always_comb begin
    m_sclk  = sel ? sclk1 : sclk0;
    m_mosi  = sel ? mosi1 : mosi0;
    m_cs_n  = sel ? cs_n1 : cs_n0;
    m_ready = sel ? bus1.req_ready : bus0.req_ready;
    m_done  = sel ? bus1.done : bus0.done;
    m_error = sel ? bus1.error : bus0.error;
    m_rdata = sel ? bus1.rsp_rdata : bus0.rsp_rdata;
  end

  // Slave model: mode 0 shifts on trailing edges, mode 3 on leading edges; the master's
  // mosi is captured on the opposite (sampling) edge. Response bits: 9 zeros, then data.
  always @(negedge clk) begin
    if (m_done === 1'b1) done_cnt++;
    if (m_cs_n === 2'b00) cs_viol++;
    if (m_sclk !== prev_sclk) sclk_cnt++;
    if (m_cs_n != 2'b11 && prev_cs_n != 2'b11 && m_mosi !== prev_mosi &&
        !(prev_sclk === 1'b1 && m_sclk === 1'b0)) mosi_viol++;
    if (m_cs_n === 2'b11) begin
      sh_cnt = 0;
      miso   = 1'b0;
    end else begin
      if (m_sclk !== prev_sclk) begin
        if ((m_sclk != sel) == !sel) begin
          cap_val = (cap_val << 1) | int'(m_mosi);
          n_cap++;
        end else begin
          sh_cnt++;
        end
      end
      idx  = sel ? sh_cnt - 1 : sh_cnt;
      miso = (idx >= 9 && idx <= 16) ? slave_data[16-idx] : 1'b0;
    end
    prev_sclk = m_sclk;
    prev_mosi = m_mosi;
    prev_cs_n = m_cs_n;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Call just after a negedge. Runs one request on the selected instance and checks
  // per-cycle cs_n/done/error/req_ready, the serial frame, edge count and rsp_rdata.
  task automatic run_txn(input bit wr, input logic [1:0] cs, input logic [7:0] addr,
                         input logic [7:0] data, input logic [7:0] sdata, input bit hold);
    int  w, lat, snap, exp_frame, exp_cs;
    int  cs_e, done_e, err_e, rdy_e;
    bit  bad;
    bad       = (cs >= 2'd2);
    lat       = bad ? 1 : (2 * 17 + 2) * (sel ? 1 : 2) + 1;
    exp_frame = (int'(wr) << 16) | (int'(addr) << 8) | (wr ? int'(data) : 0);
    cs_e = 0; done_e = 0; err_e = 0; rdy_e = 0;
    w = 0;
    while (m_ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    last_wait = w;
    check("ready before accept", {31'd0, m_ready}, 32'd1);
    req_valid  = 1'b1;
    req_write  = wr;
    req_cs     = cs;
    req_addr   = addr;
    req_wdata  = data;
    slave_data = sdata;
    @(posedge clk);
    #1;
    cap_val = 0;
    n_cap   = 0;
    snap    = sclk_cnt;
    if (!hold) req_valid = 1'b0;
    req_write = ~wr;
    req_cs    = 2'($urandom);
    req_addr  = 8'($urandom);
    req_wdata = 8'($urandom);
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      exp_cs = (!bad && k < lat) ? 3 - (1 << cs) : 3;
      if (m_cs_n !== 2'(exp_cs)) cs_e++;
      if (m_done !== (k == lat)) done_e++;
      if (m_error !== (bad && k == lat)) err_e++;
      if (m_ready !== (k > lat)) rdy_e++;
    end
    if (!bad && !wr) exp_rdata[sel] = sdata;
    check("cs_n timing", cs_e, 0);
    check("done timing", done_e, 0);
    check("error timing", err_e, 0);
    check("req_ready timing", rdy_e, 0);
    check("rsp_rdata", {24'd0, m_rdata}, {24'd0, exp_rdata[sel]});
    check("sclk edge count", sclk_cnt - snap, bad ? 0 : 34);
    check("sclk idle level", {31'd0, m_sclk}, {31'd0, sel});
    if (!bad) begin
      check("mosi bit count", n_cap, 17);
      check("mosi frame", cap_val, exp_frame);
    end
  endtask

  initial begin
    int snap_done;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_cs    = 2'd0;
    req_addr  = 8'd0;
    req_wdata = 8'd0;
    slave_data = 8'd0;
    exp_rdata[0] = 8'd0;
    exp_rdata[1] = 8'd0;
    sel = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check("reset req_ready", {31'd0, m_ready}, 32'd1);
      check("reset done", {31'd0, m_done}, 32'd0);
      check("reset error", {31'd0, m_error}, 32'd0);
      check("reset rsp_rdata", {24'd0, m_rdata}, 32'd0);
      check("reset sclk", {31'd0, m_sclk}, {31'd0, sel});
      check("reset cs_n", {30'd0, m_cs_n}, 32'd3);
      check("reset mosi", {31'd0, m_mosi}, 32'd0);
    end
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Mode 0, CLK_DIV=2: directed write, read, out-of-range selects
    run_txn(1'b1, 2'd0, 8'h3C, 8'hA5, 8'h00, 1'b0);
    run_txn(1'b0, 2'd1, 8'h10, 8'h00, 8'h5A, 1'b0);
    run_txn(1'b0, 2'd2, 8'h44, 8'h00, 8'hC3, 1'b0);
    run_txn(1'b1, 2'd3, 8'h81, 8'h7E, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) begin
      run_txn(1'($urandom), 2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    end

    // Back-to-back with req_valid held: second accept must need no wait
    run_txn(1'b1, 2'd1, 8'($urandom), 8'($urandom), 8'h00, 1'b1);
    run_txn(1'b0, 2'd0, 8'($urandom), 8'h00, 8'($urandom), 1'b0);
    check("back-to-back accept wait", last_wait, 0);

    // Mode 3, CLK_DIV=1
    @(posedge clk);
    #1;
    sel = 1'b1;
    @(negedge clk);
    run_txn(1'b1, 2'd0, 8'hFF, 8'h00, 8'h00, 1'b0);
    run_txn(1'b0, 2'd1, 8'h10, 8'h00, 8'h96, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_txn(1'($urandom), 2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    end

    // Mode 0 read aborted by reset in cycle 20
    @(posedge clk);
    #1;
    sel = 1'b0;
    @(negedge clk);
    run_txn(1'b0, 2'd1, 8'h22, 8'h00, 8'hE7, 1'b0);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_cs    = 2'd1;
    req_addr  = 8'h55;
    slave_data = 8'h3B;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    snap_done = done_cnt;
    repeat (19) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort cs_n", {30'd0, m_cs_n}, 32'd3);
    check("abort sclk", {31'd0, m_sclk}, 32'd0);
    check("abort mosi", {31'd0, m_mosi}, 32'd0);
    check("abort rsp_rdata", {24'd0, m_rdata}, 32'd0);
    exp_rdata[0] = 8'd0;
    exp_rdata[1] = 8'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    check("abort no done", done_cnt - snap_done, 0);
    check("abort req_ready", {31'd0, m_ready}, 32'd1);
    check("abort cs_n idle", {30'd0, m_cs_n}, 32'd3);
    check("abort rsp_rdata held", {24'd0, m_rdata}, 32'd0);

    check("cs_n one-hot", cs_viol, 0);
    check("mosi changes on falling sclk", mosi_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
